count_seq_monitor: RTL and testbench

Downstream checker for the free-running `four_bitcounter`. It samples the counter's `q` output every clock and checks that each step is a +1 increment modulo 2^WIDTH. It also counts wrap-arounds (max→0) and flags sequence faults. It sits beside the counter in the top-level and in benches, and gives a self-checking view of counter health without scoreboarding in the testbench.

---
 rtl/counter_mon_pkg.sv | 8 +
 rtl/sat_counter.sv | 14 +
 rtl/count_seq_monitor.sv | 71 +++++++
 tb/tb_count_seq_monitor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/counter_mon_pkg.sv
// counter_mon_pkg: shared state encoding and default parameters for the counter monitor
package counter_mon_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, LOCKED = 2'd2, FAULT = 2'd3} state_t;
   localparam int DEF_WIDTH      = 4;
   localparam int DEF_LOCK_LEN   = 2;
   localparam int DEF_WRAP_CNT_W = 8;
   localparam int DEF_ERR_CNT_W  = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of rolling over
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   // count events until full scale, then hold
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks +1 stepping of an upstream counter; STICKY_FAULT_EN makes FAULT absorbing
module count_seq_monitor
   import counter_mon_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LOCK_LEN   = DEF_LOCK_LEN,
   parameter int WRAP_CNT_W = DEF_WRAP_CNT_W,
   parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      cnt_in,
   input  logic                  cnt_clr,
   output logic                  locked,
   output logic                  fault,
   output logic                  wrap_pulse,
   output logic                  err_pulse,
   output logic [WRAP_CNT_W-1:0] wrap_cnt,
   output logic [ERR_CNT_W-1:0]  err_cnt
);
   localparam int RW = $clog2(LOCK_LEN + 1);
   state_t           state;
   logic [WIDTH-1:0] prev, nxt;
   logic [RW-1:0]    run;
   logic             step_ok, wrap_ev, err_ev;
   assign nxt     = prev + 1'b1;
   assign step_ok = cnt_in == nxt;
   assign wrap_ev = !rst && !cnt_clr && step_ok && prev == '1 && (state == SYNC || state == LOCKED);
   assign err_ev  = !rst && !cnt_clr && !step_ok && state == LOCKED;
   assign locked  = state == LOCKED;
   assign fault   = state == FAULT;
   // sequence tracking FSM; a counter clear forces resync but leaves statistics alone
   always_ff @(posedge clk)
      if (rst) begin
         state      <= IDLE;
         prev       <= '0;
         run        <= '0;
         wrap_pulse <= 1'b0;
         err_pulse  <= 1'b0;
      end else if (cnt_clr) begin
         state      <= IDLE;
         run        <= '0;
         wrap_pulse <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         prev       <= cnt_in;
         wrap_pulse <= wrap_ev;
         err_pulse  <= err_ev;
         case (state)
            IDLE: begin
               run   <= '0;
               state <= SYNC;
            end
            SYNC:
               if (!step_ok) run <= '0;
               else if (run == RW'(LOCK_LEN - 1)) state <= LOCKED;
               else run <= run + 1'b1;
            LOCKED: if (!step_ok) state <= FAULT;
            FAULT: begin
`ifdef STICKY_FAULT_EN
               state <= FAULT;
`else
               state <= SYNC;
               run   <= '0;
`endif
            end
         endcase
      end
   sat_counter #(.W(WRAP_CNT_W)) u_wrap (.clk(clk), .rst(rst), .inc(wrap_ev), .cnt(wrap_cnt));
   sat_counter #(.W(ERR_CNT_W))  u_err  (.clk(clk), .rst(rst), .inc(err_ev),  .cnt(err_cnt));
endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor: scoreboard bench with a step-rule reference model and random counter faults
module tb_count_seq_monitor;
   localparam int LL = 2;
   localparam int WMAX = 3;
   localparam int EMAX = 7;
   typedef struct packed {
      logic       lk, ft, wp, ep;
      logic [1:0] wc;
      logic [2:0] ec;
   } exp_t;
   logic       clk = 0, rst = 1, cnt_clr = 0;
   logic [3:0] cnt_in = 0;
   logic       locked, fault, wrap_pulse, err_pulse;
   logic [1:0] wrap_cnt;
   logic [2:0] err_cnt;
   int checks = 0, errors = 0;
   exp_t q[$];
   // reference model: phase 0 idle, 1 syncing, 2 locked, 3 fault
   int m_ph = 0, m_good = 0, m_prev = 0, m_wc = 0, m_ec = 0;
   bit m_wp = 0, m_ep = 0;
   logic [3:0] ctr;

   count_seq_monitor #(.WIDTH(4), .LOCK_LEN(LL), .WRAP_CNT_W(2), .ERR_CNT_W(3)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_clr(cnt_clr), .locked(locked), .fault(fault),
      .wrap_pulse(wrap_pulse), .err_pulse(err_pulse), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt));

   always #5 clk = ~clk;

   task automatic cmp(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
      end
   endtask

   // drive one cycle of inputs and queue the outputs expected after the coming edge
   task automatic cyc(input bit r, input bit c, input int x);
      bit ok;
      @(negedge clk);
      rst = r;
      cnt_clr = c;
      cnt_in = 4'(x);
      x = x % 16;
      if (r) begin
         m_ph = 0; m_good = 0; m_prev = 0; m_wc = 0; m_ec = 0; m_wp = 0; m_ep = 0;
      end else if (c) begin
         m_ph = 0; m_good = 0; m_wp = 0; m_ep = 0;
      end else begin
         ok = x == (m_prev + 1) % 16;
         m_wp = ok && m_prev == 15 && (m_ph == 1 || m_ph == 2);
         m_ep = !ok && m_ph == 2;
         if (m_wp && m_wc < WMAX) m_wc++;
         if (m_ep && m_ec < EMAX) m_ec++;
         if (m_ph == 0) begin
            m_ph = 1; m_good = 0;
         end else if (m_ph == 1) begin
            m_good = ok ? m_good + 1 : 0;
            if (m_good >= LL) m_ph = 2;
         end else if (m_ph == 2) begin
            if (!ok) m_ph = 3;
         end else begin
`ifndef STICKY_FAULT_EN
            m_ph = 1; m_good = 0;
`endif
         end
         m_prev = x;
      end
      q.push_back('{m_ph == 2, m_ph == 3, m_wp, m_ep, 2'(m_wc), 3'(m_ec)});
   endtask

   task automatic run(input int n);
      repeat (n) begin
         cyc(0, 0, ctr);
         ctr++;
      end
   endtask

   // directed spot check just after the edge that consumed the last cycle
   task automatic dchk(input string n, input int act, input int exp);
      cmp(n, act, exp);
   endtask

   task automatic settle;
      @(posedge clk);
      #2;
   endtask

   // monitor: every edge the DUT presents a full output set; pop and compare
   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         cmp("locked", locked, e.lk);
         cmp("fault", fault, e.ft);
         cmp("wrap_pulse", wrap_pulse, e.wp);
         cmp("err_pulse", err_pulse, e.ep);
         cmp("wrap_cnt", wrap_cnt, e.wc);
         cmp("err_cnt", err_cnt, e.ec);
      end
   end

   initial begin
      bit r, c;
      int x;
      cyc(1, 0, 0);
      settle();
      dchk("reset_locked", locked, 0);
      dchk("reset_wrap_cnt", wrap_cnt, 0);
      ctr = 0;
      run(20);
      settle();
      dchk("freerun_locked", locked, 1);
      dchk("freerun_wrap_cnt", wrap_cnt, 1);
      dchk("freerun_err_cnt", err_cnt, 0);
      dchk("freerun_fault", fault, 0);
      while (ctr != 7) run(1);
      cyc(0, 1, 7);
      ctr = 0;
      settle();
      dchk("clr_unlock", locked, 0);
      dchk("clr_no_err", err_pulse, 0);
      run(2);
      settle();
      dchk("clr_still_sync", locked, 0);
      run(1);
      settle();
      dchk("clr_relock", locked, 1);
      dchk("clr_wrap_held", wrap_cnt, 1);
      while (ctr != 5) run(1);
      run(1);
      cyc(0, 0, 7);
      ctr = 8;
      settle();
      dchk("skip_err_pulse", err_pulse, 1);
      dchk("skip_err_cnt", err_cnt, 1);
      dchk("skip_fault", fault, 1);
`ifdef STICKY_FAULT_EN
      run(3);
      settle();
      dchk("sticky_fault_hold", fault, 1);
      cyc(0, 1, ctr);
      ctr = 0;
      run(3);
      settle();
      dchk("sticky_relock", locked, 1);
`else
      run(1);
      settle();
      dchk("fault_one_cycle", fault, 0);
      dchk("err_pulse_one_cycle", err_pulse, 0);
      run(2);
      settle();
      dchk("fault_relock", locked, 1);
`endif
      run(80);
      settle();
      dchk("wrap_saturate", wrap_cnt, 3);
      cyc(0, 1, ctr + 3);
      ctr = 0;
      settle();
      dchk("clr_bad_no_err", err_pulse, 0);
      dchk("clr_bad_err_cnt", err_cnt, 1);
      dchk("clr_bad_unlocked", locked, 0);
      run(4);
      cyc(0, 0, ctr + 2);
      ctr = ctr + 3;
      settle();
      dchk("fault_before_rst", fault, 1);
      dchk("err_cnt_before_rst", err_cnt, 2);
      cyc(1, 0, ctr);
      ctr = 0;
      settle();
      dchk("rst_fault", fault, 0);
      dchk("rst_wrap_cnt", wrap_cnt, 0);
      dchk("rst_err_cnt", err_cnt, 0);
      repeat (3000) begin
         r = $urandom_range(0, 199) == 0;
         c = !r && $urandom_range(0, 39) == 0;
         x = ($urandom_range(0, 19) == 0) ? ctr + $urandom_range(2, 15) : ctr;
         cyc(r, c, x);
         ctr = (r || c) ? 4'd0 : 4'(x + 1);
      end
      repeat (3) @(posedge clk);
      #2;
      cmp("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
